// File: rtl/calc_entry_ctrl_if.sv
// calc_entry_ctrl_if
//   Bundles the keypad strobe, the ALU req/ack handshake and the display
//   outputs of calc_entry_ctrl.
//   slave  : the sequencer side (consumes keys and ALU responses,
//            drives the ALU request and the display).
//   master : the environment side (keypad decoder, ALU and display path).
//   OP_W sets the operand and display width and must match the sequencer.
interface calc_entry_ctrl_if #(
    parameter int unsigned OP_W = 14
);
    logic            key_valid;
    logic [3:0]      key_code;
    logic            alu_req;
    logic [1:0]      alu_op;
    logic [OP_W-1:0] alu_a;
    logic [OP_W-1:0] alu_b;
    logic            alu_ack;
    logic [15:0]     alu_result;
    logic            alu_err;
    logic [OP_W-1:0] disp_value;
    logic            disp_err;
    logic            busy;

    modport slave (
        input  key_valid, key_code, alu_ack, alu_result, alu_err,
        output alu_req, alu_op, alu_a, alu_b, disp_value, disp_err, busy
    );

    modport master (
        output key_valid, key_code, alu_ack, alu_result, alu_err,
        input  alu_req, alu_op, alu_a, alu_b, disp_value, disp_err, busy
    );
endinterface

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl
//   Sequencer between the keypad decoder and the calculator ALU. Builds two
//   decimal operands and an operator from one-cycle key strobes, issues a
//   compute request over a req/ack handshake and holds the value to display.
//   Ports:
//     i_clk   : system clock, rising edge
//     i_rst_n : synchronous active-low reset
//     bus     : calc_entry_ctrl_if.slave
//               key_valid/key_code in; alu_req/alu_op/alu_a/alu_b out;
//               alu_ack/alu_result/alu_err in; disp_value/disp_err/busy out
//   Key codes: 0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 '#', 15 '*'.
module calc_entry_ctrl #(
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned OP_W       = 14
) (
    input logic              i_clk,
    input logic              i_rst_n,
    calc_entry_ctrl_if.slave bus
);

    localparam int unsigned MAX_VAL = (10 ** MAX_DIGITS) - 1;
    localparam int unsigned CNT_W   = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        ST_ENTRY_A,
        ST_OP_WAIT,
        ST_ENTRY_B,
        ST_REQ,
        ST_SHOW,
        ST_ERR
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [OP_W-1:0] r_a, w_a_nxt;
    logic [OP_W-1:0] r_b, w_b_nxt;
    logic [1:0]      r_op, w_op_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [OP_W-1:0] r_result, w_result_nxt;

    logic            w_is_digit;
    logic            w_is_oper;
    logic            w_is_eq;
    logic            w_is_clr;
    logic [1:0]      w_key_op;
    logic [3:0]      w_digit;
    logic            w_cnt_full;
    logic [CNT_W-1:0] w_cnt_first;
    logic [OP_W-1:0] w_a_app;
    logic [OP_W-1:0] w_b_app;
    logic            w_res_bad;

    // v*10 + d via shifts, evaluated 4 bits wider than the operand. The
    // digit cap keeps the true result within MAX_VAL, so truncating is safe.
    function automatic logic [OP_W-1:0] f_append(input logic [OP_W-1:0] v,
                                                 input logic [3:0]      d);
        logic [OP_W+3:0] w_wide;
        w_wide = ((OP_W+4)'(v) << 3) + ((OP_W+4)'(v) << 1) + (OP_W+4)'(d);
        return w_wide[OP_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Key decode
    // ------------------------------------------------------------------
    always_comb begin
        w_is_digit = bus.key_valid && (bus.key_code <= 4'd9);
        w_is_oper  = bus.key_valid && (bus.key_code >= 4'd10) && (bus.key_code <= 4'd13);
        w_is_eq    = bus.key_valid && (bus.key_code == 4'd14);
        w_is_clr   = bus.key_valid && (bus.key_code == 4'd15);
        w_key_op   = 2'(bus.key_code - 4'd10);
        w_digit    = bus.key_code;
    end

    assign w_cnt_full  = (r_cnt == CNT_W'(MAX_DIGITS));
    // A leading zero does not occupy a digit position.
    assign w_cnt_first = (w_digit != 4'd0) ? CNT_W'(1) : '0;
    assign w_a_app     = f_append(r_a, w_digit);
    assign w_b_app     = f_append(r_b, w_digit);
    assign w_res_bad   = bus.alu_err || (32'(bus.alu_result) > MAX_VAL);

    // ------------------------------------------------------------------
    // State and register update
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_ENTRY_A;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_op     <= w_op_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_op_nxt     = r_op;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;

        // '*' clears from every state except REQ, where all keys are held off
        // so the operands stay stable for the ALU.
        if (w_is_clr && (r_state != ST_REQ)) begin
            w_state_nxt = ST_ENTRY_A;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_op_nxt    = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_ENTRY_A: begin
                    if (w_is_digit) begin
                        if (!w_cnt_full && !((r_a == '0) && (w_digit == 4'd0))) begin
                            w_a_nxt   = w_a_app;
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else if (w_is_oper) begin
                        w_op_nxt    = w_key_op;
                        w_state_nxt = ST_OP_WAIT;
                    end
                end

                ST_OP_WAIT: begin
                    if (w_is_digit) begin
                        w_b_nxt     = OP_W'(w_digit);
                        w_cnt_nxt   = w_cnt_first;
                        w_state_nxt = ST_ENTRY_B;
                    end else if (w_is_oper) begin
                        w_op_nxt = w_key_op;
                    end
                end

                ST_ENTRY_B: begin
                    // Operators are ignored here: no chained expressions.
                    if (w_is_digit) begin
                        if (!w_cnt_full && !((r_b == '0) && (w_digit == 4'd0))) begin
                            w_b_nxt   = w_b_app;
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else if (w_is_eq) begin
                        w_state_nxt = ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (bus.alu_ack) begin
                        if (w_res_bad) begin
                            w_state_nxt = ST_ERR;
                        end else begin
                            w_result_nxt = bus.alu_result[OP_W-1:0];
                            w_state_nxt  = ST_SHOW;
                        end
                    end
                end

                ST_SHOW: begin
                    if (w_is_digit) begin
                        w_a_nxt     = OP_W'(w_digit);
                        w_cnt_nxt   = w_cnt_first;
                        w_b_nxt     = '0;
                        w_state_nxt = ST_ENTRY_A;
                    end else if (w_is_oper) begin
                        w_a_nxt     = r_result;
                        w_op_nxt    = w_key_op;
                        w_state_nxt = ST_OP_WAIT;
                    end
                end

                ST_ERR: begin
                end

                default: begin
                    w_state_nxt = ST_ENTRY_A;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state
    // ------------------------------------------------------------------
    assign bus.alu_req  = (r_state == ST_REQ);
    assign bus.busy     = (r_state == ST_REQ);
    assign bus.alu_op   = r_op;
    assign bus.alu_a    = r_a;
    assign bus.alu_b    = r_b;
    assign bus.disp_err = (r_state == ST_ERR);

    always_comb begin
        bus.disp_value = '0;
        case (r_state)
            ST_ENTRY_A: bus.disp_value = r_a;
            ST_OP_WAIT: bus.disp_value = r_a;
            ST_ENTRY_B: bus.disp_value = r_b;
            ST_REQ:     bus.disp_value = r_b;   // keep the last entry visible
            ST_SHOW:    bus.disp_value = r_result;
            default:    bus.disp_value = '0;
        endcase
    end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl
//   Directed bench for calc_entry_ctrl: a table of single-key vectors with
//   expected display state, followed by hand-written handshake, error,
//   boundary and reset sequences. Inputs change and outputs are sampled on
//   the falling clock edge.
module tb_calc_entry_ctrl;

    localparam int unsigned OP_W = 14;

    logic i_clk;
    logic i_rst_n;

    calc_entry_ctrl_if #(.OP_W(OP_W)) bus ();

    calc_entry_ctrl #(
        .MAX_DIGITS(4),
        .OP_W      (OP_W)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int unsigned n_checks;
    int unsigned n_errors;

    typedef struct {
        logic [3:0]  key;
        int unsigned disp;
        logic        err;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic press(input logic [3:0] k);
        step();
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        step();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
    endtask

    // Called on a falling edge; ack is seen by the next rising edge.
    task automatic ack_with(input logic [15:0] res, input logic err);
        bus.alu_ack    = 1'b1;
        bus.alu_result = res;
        bus.alu_err    = err;
        step();
        bus.alu_ack    = 1'b0;
        bus.alu_result = 16'd0;
        bus.alu_err    = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] k, input int unsigned d);
        vec_t v;
        v.key  = k;
        v.disp = d;
        v.err  = 1'b0;
        v.busy = 1'b0;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        i_rst_n        = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'd0;
        bus.alu_ack    = 1'b0;
        bus.alu_result = 16'd0;
        bus.alu_err    = 1'b0;

        // Digit entry, cap, leading zeros, '#'/operator handling.
        tbl.push_back(mk(4'd1, 1));
        tbl.push_back(mk(4'd2, 12));
        tbl.push_back(mk(4'd3, 123));
        tbl.push_back(mk(4'd4, 1234));
        tbl.push_back(mk(4'd5, 1234));
        tbl.push_back(mk(4'd14, 1234));
        tbl.push_back(mk(4'd15, 0));
        tbl.push_back(mk(4'd0, 0));
        tbl.push_back(mk(4'd0, 0));
        tbl.push_back(mk(4'd7, 7));
        tbl.push_back(mk(4'd1, 71));
        tbl.push_back(mk(4'd2, 712));
        tbl.push_back(mk(4'd3, 7123));
        tbl.push_back(mk(4'd4, 7123));
        tbl.push_back(mk(4'd10, 7123));
        tbl.push_back(mk(4'd11, 7123));
        tbl.push_back(mk(4'd0, 0));
        tbl.push_back(mk(4'd0, 0));
        tbl.push_back(mk(4'd5, 5));
        tbl.push_back(mk(4'd12, 5));
        tbl.push_back(mk(4'd3, 53));
        tbl.push_back(mk(4'd15, 0));

        repeat (3) step();
        i_rst_n = 1'b1;
        step();

        chk("rst_alu_req", 32'(bus.alu_req), 0);
        chk("rst_alu_op", 32'(bus.alu_op), 0);
        chk("rst_alu_a", 32'(bus.alu_a), 0);
        chk("rst_alu_b", 32'(bus.alu_b), 0);
        chk("rst_disp_value", 32'(bus.disp_value), 0);
        chk("rst_disp_err", 32'(bus.disp_err), 0);
        chk("rst_busy", 32'(bus.busy), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            press(tbl[i].key);
            chk($sformatf("vec%0d_disp", i), 32'(bus.disp_value), tbl[i].disp);
            chk($sformatf("vec%0d_err", i), 32'(bus.disp_err), 32'(tbl[i].err));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
        end

        // 123 + 45, ack in the third request cycle.
        press(4'd1); press(4'd2); press(4'd3); press(4'd10);
        press(4'd4); press(4'd5); press(4'd14);
        chk("add_req_c1", 32'(bus.alu_req), 1);
        chk("add_busy", 32'(bus.busy), 1);
        chk("add_alu_a", 32'(bus.alu_a), 123);
        chk("add_alu_b", 32'(bus.alu_b), 45);
        chk("add_alu_op", 32'(bus.alu_op), 0);
        step();
        chk("add_req_c2", 32'(bus.alu_req), 1);
        step();
        chk("add_req_c3", 32'(bus.alu_req), 1);
        ack_with(16'd168, 1'b0);
        chk("add_req_done", 32'(bus.alu_req), 0);
        chk("add_busy_done", 32'(bus.busy), 0);
        chk("add_disp", 32'(bus.disp_value), 168);
        chk("add_err", 32'(bus.disp_err), 0);

        // No repeat-equals from SHOW.
        press(4'd14);
        chk("show_eq_req", 32'(bus.alu_req), 0);
        chk("show_eq_disp", 32'(bus.disp_value), 168);

        // Chain from result: 168 - 8.
        press(4'd11);
        chk("chain_opwait_disp", 32'(bus.disp_value), 168);
        press(4'd8);
        chk("chain_b_disp", 32'(bus.disp_value), 8);
        press(4'd14);
        chk("chain_alu_a", 32'(bus.alu_a), 168);
        chk("chain_alu_b", 32'(bus.alu_b), 8);
        chk("chain_alu_op", 32'(bus.alu_op), 1);
        chk("chain_req", 32'(bus.alu_req), 1);

        // Keys during REQ are ignored, including '*'.
        press(4'd15);
        press(4'd5);
        chk("req_keys_a", 32'(bus.alu_a), 168);
        chk("req_keys_b", 32'(bus.alu_b), 8);
        chk("req_keys_op", 32'(bus.alu_op), 1);
        chk("req_keys_req", 32'(bus.alu_req), 1);

        // '*' coincident with the ack cycle is ignored.
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd15;
        ack_with(16'd160, 1'b0);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        chk("coinc_disp", 32'(bus.disp_value), 160);
        chk("coinc_req", 32'(bus.alu_req), 0);

        // Digit from SHOW starts a new A and clears B.
        press(4'd3);
        chk("show_digit_disp", 32'(bus.disp_value), 3);
        chk("show_digit_b", 32'(bus.alu_b), 0);

        // Ack outside REQ is ignored.
        ack_with(16'd0, 1'b1);
        chk("stray_ack_err", 32'(bus.disp_err), 0);
        chk("stray_ack_disp", 32'(bus.disp_value), 3);

        // 8 / 0 with ALU error.
        press(4'd15); press(4'd8); press(4'd13); press(4'd0); press(4'd14);
        chk("div_alu_op", 32'(bus.alu_op), 3);
        chk("div_alu_a", 32'(bus.alu_a), 8);
        chk("div_alu_b", 32'(bus.alu_b), 0);
        chk("div_req", 32'(bus.alu_req), 1);
        ack_with(16'd0, 1'b1);
        chk("div_err", 32'(bus.disp_err), 1);
        chk("div_disp", 32'(bus.disp_value), 0);
        chk("div_req_done", 32'(bus.alu_req), 0);
        press(4'd7);
        chk("err_digit_err", 32'(bus.disp_err), 1);
        chk("err_digit_disp", 32'(bus.disp_value), 0);
        press(4'd10);
        chk("err_oper_err", 32'(bus.disp_err), 1);
        press(4'd15);
        chk("err_clr_err", 32'(bus.disp_err), 0);
        chk("err_clr_disp", 32'(bus.disp_value), 0);
        press(4'd5);
        chk("err_clr_entry", 32'(bus.disp_value), 5);

        // 9999 * 2 overflows the display range.
        press(4'd15); press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        press(4'd12); press(4'd2); press(4'd14);
        chk("mul_alu_a", 32'(bus.alu_a), 9999);
        chk("mul_alu_b", 32'(bus.alu_b), 2);
        chk("mul_alu_op", 32'(bus.alu_op), 2);
        ack_with(16'd19998, 1'b0);
        chk("mul_ovf_err", 32'(bus.disp_err), 1);
        chk("mul_ovf_disp", 32'(bus.disp_value), 0);

        // Result exactly MAX_VAL is shown; MAX_VAL+1 is an error.
        press(4'd15); press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        press(4'd12); press(4'd1); press(4'd14);
        ack_with(16'd9999, 1'b0);
        chk("max_err", 32'(bus.disp_err), 0);
        chk("max_disp", 32'(bus.disp_value), 9999);
        press(4'd10); press(4'd1); press(4'd14);
        chk("max_chain_a", 32'(bus.alu_a), 9999);
        ack_with(16'd10000, 1'b0);
        chk("max1_err", 32'(bus.disp_err), 1);
        press(4'd15);

        // Reset in the middle of a request.
        press(4'd1); press(4'd11); press(4'd2); press(4'd14);
        chk("mid_req_req", 32'(bus.alu_req), 1);
        chk("mid_req_op", 32'(bus.alu_op), 1);
        i_rst_n = 1'b0;
        step();
        chk("mid_rst_req", 32'(bus.alu_req), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_op", 32'(bus.alu_op), 0);
        chk("mid_rst_a", 32'(bus.alu_a), 0);
        chk("mid_rst_b", 32'(bus.alu_b), 0);
        chk("mid_rst_disp", 32'(bus.disp_value), 0);
        chk("mid_rst_err", 32'(bus.disp_err), 0);
        i_rst_n = 1'b1;
        ack_with(16'd5, 1'b0);
        chk("late_ack_req", 32'(bus.alu_req), 0);
        chk("late_ack_disp", 32'(bus.disp_value), 0);
        chk("late_ack_err", 32'(bus.disp_err), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Sequencer between the keypad decoder and the calculator ALU. It consumes one-cycle key-code strobes and builds two decimal operands plus an operator. It issues a compute request to the ALU over a req/ack handshake and holds the value to be displayed. The BCD conversion and 7-segment driving are downstream and outside this block.

## Interface
- MAX_DIGITS, 4, maximum decimal digits per operand; MAX_VAL = 10^MAX_DIGITS − 1 (localparam)
- OP_W, 14, operand/display width in bits; must satisfy 2^OP_W > MAX_VAL
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0–9 digit, 10 A=add, 11 B=sub, 12 C=mul, 13 D=div, 14 '#'=equals, 15 '*'=clear
- alu_req  out  1  compute request
- alu_op  out  2  0 add, 1 sub, 2 mul, 3 div
- alu_a, alu_b  out  OP_W  operands
- alu_ack  in  1  result valid, sampled only while alu_req=1
- alu_result  in  16  unsigned result
- alu_err  in  1  ALU error (negative, divide-by-zero), qualified by alu_ack
- disp_value  out  OP_W  value to display
- disp_err  out  1  error indicator
- busy  out  1  high in REQ

## Operation
- States: ENTRY_A, OP_WAIT, ENTRY_B, REQ, SHOW, ERR. Reset → ENTRY_A.
- Registers: a, b (OP_W), op (2), cnt (digit count), result latch.
- Digit append: v ← v*10 + d, computed as (v<<3)+(v<<1)+d at OP_W+4 bits, then truncated. The digit cap guarantees the result is ≤ MAX_VAL.
- A digit is ignored when cnt == MAX_DIGITS.
- Digit 0 while v==0: v stays 0 and cnt is not incremented.
- '*' in any state except REQ: a=b=op=cnt=0, disp_err=0, go to ENTRY_A.
- ENTRY_A:
  - digit → append to a.
  - operator → latch op, go to OP_WAIT.
  - '#' → ignored.
  - disp_value=a.
- OP_WAIT:
  - digit d → b=d, cnt=1 (cnt=0 if d=0), go to ENTRY_B.
  - operator → replace op.
  - '#' → ignored.
  - disp_value=a.
- ENTRY_B:
  - digit → append to b.
  - '#' → go to REQ.
  - operator → ignored (no chaining mid-entry).
  - disp_value=b.
- REQ:
  - alu_req=1; alu_a, alu_b, alu_op stay stable until ack.
  - All keys are ignored, including '*'.
  - On alu_ack: if alu_err or alu_result > MAX_VAL, go to ERR. Otherwise latch result[OP_W-1:0] and go to SHOW.
- SHOW:
  - disp_value=result.
  - digit d → a=d, cnt per append rule, b=0, go to ENTRY_A.
  - operator → a=result, op latched, go to OP_WAIT.
  - '#' → ignored (no repeat-equals).
- ERR:
  - disp_err=1, disp_value=0.
  - Only '*' acts; every other key is ignored.
- alu_ack outside REQ is ignored.
- key_valid on consecutive cycles counts as separate keys.

## Timing
- Reset values: alu_req=0, alu_op=0, alu_a=0, alu_b=0, disp_value=0, disp_err=0, busy=0, state ENTRY_A.
- All outputs are registered or decoded from registered state.
- Key strobe at cycle n → state, registers and disp_value update visibly at n+1.
- '#' at cycle n → alu_req=busy=1 from n+1.
- alu_ack may be asserted in the first cycle alu_req is high, which allows a combinational ALU.
- alu_ack sampled high at cycle m → at m+1: alu_req=0, busy=0, disp_value/disp_err updated.
- A key strobe coincident with the acking cycle is ignored, because the block is still in REQ.
- rst_n low at any edge, including mid-REQ: all outputs return to reset values on that edge and alu_req drops. An ack arriving afterwards is ignored.

## Test plan
- Reset, keys 1,2,3,A,4,5,#; ALU acks after 3 cycles with 168.
  - Required: alu_a=123, alu_b=45, alu_op=0; alu_req high exactly 3 cycles; then disp_value=168, busy=0.
- Keys 1,2,3,4,5.
  - Required: disp_value=1234; the 5 is ignored.
- Keys 0,0,7.
  - Required: disp_value=7, cnt=1; then 1,2,3 gives 7123 and a further 4 is ignored.
- Keys 8,D,0,#; ack with alu_err=1.
  - Required: disp_err=1, disp_value=0; then 7 is ignored.
  - Then '*': disp_err=0, disp_value=0, ENTRY_A.
- Keys 9,9,9,9,C,2,#; ack with result 19998.
  - Required: ERR.
- From SHOW=168, keys B,8,#.
  - Required: alu_a=168, alu_b=8, alu_op=1.
- During REQ, strobe '*' and 5.
  - Required: no effect on alu_a/alu_b/alu_op.
- rst_n low mid-REQ.
  - Required: alu_req=0 on the next edge, all outputs 0; a later ack is ignored.
